// File: rtl/assignment_driver_if.sv
// assignment_driver_if
//  Groups the host-side stimulus/result handshakes and the DUT method pins
//  (start/next) driven by assignment_driver.
//  Ports (all members):
//    host_valid/host_ready/host_data            stimulus word handshake
//    res_valid/res_ready/res_data/res_timeout   result word handshake
//    RDY_start/EN_start                         DUT start method
//    RDY_next/EN_next/next_k/next               DUT next actionvalue
//  modport slave  : the sequencer (assignment_driver)
//  modport master : the environment (host plus DUT model)
interface assignment_driver_if #(
  parameter int N_BITS = 8
);
  logic              host_valid;
  logic              host_ready;
  logic [N_BITS-1:0] host_data;
  logic              res_valid;
  logic              res_ready;
  logic [N_BITS-1:0] res_data;
  logic              res_timeout;
  logic              RDY_start;
  logic              EN_start;
  logic              RDY_next;
  logic              EN_next;
  logic              next_k;
  logic              next;

  modport slave (
    input  host_valid, host_data, res_ready, RDY_start, RDY_next, next,
    output host_ready, res_valid, res_data, res_timeout, EN_start, EN_next, next_k
  );

  modport master (
    output host_valid, host_data, res_ready, RDY_start, RDY_next, next,
    input  host_ready, res_valid, res_data, res_timeout, EN_start, EN_next, next_k
  );
endinterface

// File: rtl/assignment_driver.sv
// assignment_driver
//  Upstream sequencer for the assignment DUT. Accepts an N_BITS stimulus word
//  from the host, fires the DUT start method once, then fires the next method
//  once per bit (next_k = stimulus bits LSB-first), collecting each returned
//  bit into a result word handed back to the host. A watchdog aborts the
//  transaction if the DUT holds its RDY low for TIMEOUT consecutive cycles.
//  Parameters:
//    N_BITS  : stimulus/result width (>=1)
//    TIMEOUT : consecutive not-ready cycles before abort, 0 disables
//  Ports:
//    CLK   : clock, rising edge
//    RST_N : asynchronous active-low reset
//    bus   : assignment_driver_if.slave (host and DUT method signals)
module assignment_driver #(
  parameter int N_BITS  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  assignment_driver_if.slave   bus
);

  localparam int CNT_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam int WD_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_BITS - 1);
  // Watchdog value one short of TIMEOUT: a further idle cycle means expiry.
  localparam logic [WD_W-1:0]  WD_LAST  = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    IDLE,
    START,
    STREAM,
    DONE
  } state_t;

  state_t            state_reg,  state_next;
  logic [N_BITS-1:0] stim_reg,   stim_next;
  logic [N_BITS-1:0] res_reg,    res_next;
  logic [CNT_W-1:0]  cnt_reg,    cnt_next;
  logic [WD_W-1:0]   wd_reg,     wd_next;
  logic              to_reg,     to_next;

  logic wd_expire;
  assign wd_expire = (TIMEOUT != 0) && (wd_reg == WD_LAST);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg <= IDLE;
      stim_reg  <= '0;
      res_reg   <= '0;
      cnt_reg   <= '0;
      wd_reg    <= '0;
      to_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      stim_reg  <= stim_next;
      res_reg   <= res_next;
      cnt_reg   <= cnt_next;
      wd_reg    <= wd_next;
      to_reg    <= to_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    stim_next       = stim_reg;
    res_next        = res_reg;
    cnt_next        = cnt_reg;
    wd_next         = wd_reg;
    to_next         = to_reg;
    bus.host_ready  = 1'b0;
    bus.res_valid   = 1'b0;
    bus.EN_start    = 1'b0;
    bus.EN_next     = 1'b0;
    bus.next_k      = 1'b0;

    case (state_reg)
      IDLE: begin
        bus.host_ready = 1'b1;
        if (bus.host_valid) begin
          // Clearing the result here keeps uncollected bits at 0 on abort.
          stim_next  = bus.host_data;
          res_next   = '0;
          to_next    = 1'b0;
          cnt_next   = '0;
          wd_next    = '0;
          state_next = START;
        end
      end

      START: begin
        bus.EN_start = bus.RDY_start;
        if (bus.RDY_start) begin
          cnt_next   = '0;
          wd_next    = '0;
          state_next = STREAM;
        end else if (wd_expire) begin
          to_next    = 1'b1;
          state_next = DONE;
        end else if (TIMEOUT != 0) begin
          wd_next = wd_reg + 1'b1;
        end
      end

      STREAM: begin
        bus.next_k  = stim_reg[0];
        bus.EN_next = bus.RDY_next;
        if (bus.RDY_next) begin
          res_next[cnt_reg] = bus.next;
          stim_next         = stim_reg >> 1;
          cnt_next          = cnt_reg + 1'b1;
          wd_next           = '0;
          if (cnt_reg == CNT_LAST) begin
            state_next = DONE;
          end
        end else if (wd_expire) begin
          to_next    = 1'b1;
          state_next = DONE;
        end else if (TIMEOUT != 0) begin
          wd_next = wd_reg + 1'b1;
        end
      end

      DONE: begin
        bus.res_valid = 1'b1;
        if (bus.res_ready) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.res_data    = res_reg;
  assign bus.res_timeout = to_reg;

endmodule
